// File: rtl/seq_pkg.sv
// Shared types and default widths for the instruction sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        MEM_WAIT,
        DONE
    } seq_state_t;

    localparam int PC_W_DEF  = 12;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/prog_ctr.sv
// Program counter register with load, increment and hold.
module prog_ctr #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] load_val,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_inc
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // Natural overflow gives the all-ones -> zero wrap.
    assign pc_inc = pc_q + PC_W'(1);
    assign pc     = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_val;
        end else if (inc) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequence controller: run/stop FSM, memory wait states,
// jump/branch resolution and executed-cycle counting.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int START_ADDR = 0,
    parameter int MEM_LAT    = 1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             branchFlag,
    input  logic             brCond,
    input  logic             aluFlag,
    input  logic             memToRegFlag,
    input  logic             memWriteFlag,
    input  logic             halt,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  instr_ROM_ctr,
    output logic             instr_valid,
    output logic             stall,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int WAIT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    seq_state_t       state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [PC_W-1:0]  npc_q, npc_d;

    logic             pc_load;
    logic             pc_inc_en;
    logic [PC_W-1:0]  pc_load_val;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_inc;
    logic             take;
    logic [PC_W-1:0]  next_pc;
    logic [CNT_W-1:0] cnt_sat;
    logic             mem_op;

    prog_ctr #(
        .PC_W(PC_W)
    ) u_prog_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .inc      (pc_inc_en),
        .load_val (pc_load_val),
        .pc       (pc),
        .pc_inc   (pc_inc)
    );

    assign take    = branchFlag | (brCond & aluFlag);
    assign next_pc = take ? target : pc_inc;
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign mem_op  = memToRegFlag | memWriteFlag;

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        npc_d       = npc_q;
        pc_load     = 1'b0;
        pc_inc_en   = 1'b0;
        pc_load_val = npc_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    pc_load     = 1'b1;
                    pc_load_val = PC_W'(START_ADDR);
                    cnt_d       = '0;
                    done_d      = 1'b0;
                end
            end
            RUN: begin
                cnt_d = cnt_sat;
                if (halt) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (mem_op && (MEM_LAT > 0)) begin
                    // Resolve the branch now; inputs are ignored while stalled.
                    state_d = MEM_WAIT;
                    wait_d  = WAIT_W'(MEM_LAT);
                    npc_d   = next_pc;
                end else if (take) begin
                    pc_load     = 1'b1;
                    pc_load_val = target;
                end else begin
                    pc_inc_en = 1'b1;
                end
            end
            MEM_WAIT: begin
                cnt_d = cnt_sat;
                if (wait_q == WAIT_W'(1)) begin
                    state_d = RUN;
                    wait_d  = '0;
                    pc_load = 1'b1;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            npc_q   <= npc_d;
        end
    end

    assign instr_ROM_ctr = pc;
    assign instr_valid   = (state_q == RUN);
    assign stall         = (state_q == MEM_WAIT);
    assign done          = done_q;
    assign cycle_count   = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer (MEM_LAT=2, 12-bit PC).
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        branchFlag;
    logic        brCond;
    logic        aluFlag;
    logic        memToRegFlag;
    logic        memWriteFlag;
    logic        halt;
    logic [11:0] target;
    logic [11:0] instr_ROM_ctr;
    logic        instr_valid;
    logic        stall;
    logic        done;
    logic [15:0] cycle_count;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .PC_W(12),
        .START_ADDR(0),
        .MEM_LAT(2),
        .CNT_W(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .branchFlag   (branchFlag),
        .brCond       (brCond),
        .aluFlag      (aluFlag),
        .memToRegFlag (memToRegFlag),
        .memWriteFlag (memWriteFlag),
        .halt         (halt),
        .target       (target),
        .instr_ROM_ctr(instr_ROM_ctr),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        start = 0; branchFlag = 0; brCond = 0; aluFlag = 0;
        memToRegFlag = 0; memWriteFlag = 0; halt = 0; target = '0;
    endtask

    task automatic chk_outs(string nm, logic [11:0] pc, logic v,
                            logic s, logic d, logic [15:0] cc);
        tests_run++;
        if (instr_ROM_ctr !== pc || instr_valid !== v || stall !== s
            || done !== d || cycle_count !== cc) begin
            tests_failed++;
            $display("FAIL %s: got pc=%h v=%b s=%b d=%b cc=%0d, want pc=%h v=%b s=%b d=%b cc=%0d",
                     nm, instr_ROM_ctr, instr_valid, stall, done, cycle_count,
                     pc, v, s, d, cc);
        end
    endtask

    task automatic test_reset();
        clr_in();
        reset = 1;
        step();
        step();
        chk_outs("reset", 12'h000, 0, 0, 0, 16'd0);
        reset = 0;
        step();
        chk_outs("idle_hold", 12'h000, 0, 0, 0, 16'd0);
    endtask

    task automatic test_run();
        start = 1;
        step();
        start = 0;
        chk_outs("start", 12'h000, 1, 0, 0, 16'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk_outs($sformatf("seq%0d", i), 12'(i), 1, 0, 0, 16'(i));
        end
    endtask

    task automatic test_branch();
        step();
        step();
        chk_outs("pc7", 12'h007, 1, 0, 0, 16'd7);
        branchFlag = 1; target = 12'h020;
        step();
        chk_outs("jump", 12'h020, 1, 0, 0, 16'd8);
        branchFlag = 0; brCond = 1; aluFlag = 0; target = 12'h099;
        step();
        chk_outs("br_not_taken", 12'h021, 1, 0, 0, 16'd9);
        aluFlag = 1; target = 12'h010;
        step();
        chk_outs("br_taken", 12'h010, 1, 0, 0, 16'd10);
        clr_in();
    endtask

    task automatic test_mem_wait();
        branchFlag = 1; target = 12'h004;
        step();
        clr_in();
        chk_outs("pc4", 12'h004, 1, 0, 0, 16'd11);
        memToRegFlag = 1;
        step();
        clr_in();
        branchFlag = 1; target = 12'h100;
        chk_outs("wait1", 12'h004, 0, 1, 0, 16'd12);
        step();
        clr_in();
        chk_outs("wait2", 12'h004, 0, 1, 0, 16'd13);
        step();
        chk_outs("wait_end", 12'h005, 1, 0, 0, 16'd14);
        memWriteFlag = 1; branchFlag = 1; target = 12'h040;
        step();
        clr_in();
        chk_outs("st_wait1", 12'h005, 0, 1, 0, 16'd15);
        step();
        step();
        chk_outs("st_latched_br", 12'h040, 1, 0, 0, 16'd17);
    endtask

    task automatic test_halt();
        branchFlag = 1; target = 12'h009;
        step();
        chk_outs("pc9", 12'h009, 1, 0, 0, 16'd18);
        halt = 1; target = 12'h055;
        step();
        clr_in();
        chk_outs("halt", 12'h009, 0, 0, 1, 16'd19);
        step();
        chk_outs("done_hold", 12'h009, 0, 0, 1, 16'd19);
        start = 1;
        step();
        start = 0;
        chk_outs("restart", 12'h000, 1, 0, 0, 16'd0);
    endtask

    task automatic test_wrap();
        branchFlag = 1; target = 12'hFFF;
        step();
        clr_in();
        chk_outs("pc_fff", 12'hFFF, 1, 0, 0, 16'd1);
        step();
        chk_outs("wrap", 12'h000, 1, 0, 0, 16'd2);
    endtask

    task automatic test_reset_midwait();
        memToRegFlag = 1;
        step();
        clr_in();
        chk_outs("mw_enter", 12'h000, 0, 1, 0, 16'd3);
        reset = 1;
        step();
        reset = 0;
        chk_outs("mw_reset", 12'h000, 0, 0, 0, 16'd0);
        step();
        chk_outs("mw_idle", 12'h000, 0, 0, 0, 16'd0);
        start = 1;
        step();
        start = 0;
        branchFlag = 1; target = 12'h030;
        step();
        clr_in();
        chk_outs("pc30", 12'h030, 1, 0, 0, 16'd1);
        start = 1;
        step();
        start = 0;
        chk_outs("start_in_run", 12'h031, 1, 0, 0, 16'd2);
    endtask

    initial begin
        clr_in();
        reset = 1;
        test_reset();
        test_run();
        test_branch();
        test_mem_wait();
        test_halt();
        test_wrap();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
